// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: ID issue, WB retire and flush signals for the
// register-file scoreboard, plus its stall/status outputs.
// With SCOREBOARD_STATS_EN defined the bundle also carries stall_cycles_o.
interface regfile_scoreboard_if;
    logic        ID_valid_i;
    logic [4:0]  ID_rs1_i;
    logic [4:0]  ID_rs2_i;
    logic        ID_rs1_used_i;
    logic        ID_rs2_used_i;
    logic [4:0]  ID_rd_i;
    logic        ID_reg_wr_en_i;
    logic        EX_stall_i;
    logic        WB_retire_i;
    logic [4:0]  WB_rd_i;
    logic        WB_reg_wr_en_i;
    logic        flush_all_i;
    logic        stall_o;
    logic        issue_o;
    logic        busy_o;
    logic [5:0]  pending_cnt_o;
`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles_o;
`endif

    // Pipeline side: drives ID/WB bookkeeping, observes stall/status.
    modport master (
        output ID_valid_i, ID_rs1_i, ID_rs2_i, ID_rs1_used_i, ID_rs2_used_i,
               ID_rd_i, ID_reg_wr_en_i, EX_stall_i, WB_retire_i, WB_rd_i,
               WB_reg_wr_en_i, flush_all_i,
`ifdef SCOREBOARD_STATS_EN
        input  stall_cycles_o,
`endif
        input  stall_o, issue_o, busy_o, pending_cnt_o
    );

    // Scoreboard side.
    modport slave (
        input  ID_valid_i, ID_rs1_i, ID_rs2_i, ID_rs1_used_i, ID_rs2_used_i,
               ID_rd_i, ID_reg_wr_en_i, EX_stall_i, WB_retire_i, WB_rd_i,
               WB_reg_wr_en_i, flush_all_i,
`ifdef SCOREBOARD_STATS_EN
        output stall_cycles_o,
`endif
        output stall_o, issue_o, busy_o, pending_cnt_o
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write counters for the RV32I
// register file. Stalls ID on read-after-write hazards the register file's
// same-cycle write-through cannot cover; a writeback in the current cycle
// already counts as having cleared its hazard.
// Optional: define SCOREBOARD_STATS_EN to add stall_cycles_o, a wrapping
// count of stalled cycles cleared only by reset.

// One register's in-flight writer count.
module regfile_scoreboard_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc,
    input  logic             clr,
    input  logic             flush,
    output logic [CNT_W-1:0] cnt
);
    // Flush wins; inc+clr cancel; never wrap in either direction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt <= '0;
        else if (flush)
            cnt <= '0;
        else if (inc && !clr) begin
            if (cnt != '1) cnt <= cnt + 1'b1;
        end else if (clr && !inc) begin
            if (cnt != '0) cnt <= cnt - 1'b1;
        end
    end
endmodule

module regfile_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2
) (
    input logic                 clk_i,
    input logic                 rst_i,
    regfile_scoreboard_if.slave sb
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Entries beyond NUM_REGS and x0 read as constant zero.
    logic [31:0][CNT_W-1:0] cnt;
    logic                   wb_hit;
    logic                   clr_rs1, clr_rs2, clr_rd;
    logic                   haz1, haz2, full;
    logic                   stall, issue;
    logic [15:0]            sum;

    assign wb_hit  = sb.WB_retire_i && sb.WB_reg_wr_en_i && (sb.WB_rd_i != 5'd0);
    assign clr_rs1 = wb_hit && (sb.WB_rd_i == sb.ID_rs1_i);
    assign clr_rs2 = wb_hit && (sb.WB_rd_i == sb.ID_rs2_i);
    assign clr_rd  = wb_hit && (sb.WB_rd_i == sb.ID_rd_i);

    // Hazard / capacity check; a last writer retiring now is bypassed.
    always_comb begin
        haz1 = sb.ID_rs1_used_i && (sb.ID_rs1_i != 5'd0) &&
               (cnt[sb.ID_rs1_i] != '0) &&
               !((cnt[sb.ID_rs1_i] == CNT_ONE) && clr_rs1);
        haz2 = sb.ID_rs2_used_i && (sb.ID_rs2_i != 5'd0) &&
               (cnt[sb.ID_rs2_i] != '0) &&
               !((cnt[sb.ID_rs2_i] == CNT_ONE) && clr_rs2);
        full = sb.ID_reg_wr_en_i && (sb.ID_rd_i != 5'd0) &&
               (cnt[sb.ID_rd_i] == CNT_MAX) && !clr_rd;
    end

    assign stall = sb.ID_valid_i && (haz1 || haz2 || full);
    assign issue = sb.ID_valid_i && !stall && !sb.EX_stall_i;

    genvar r;
    generate
        for (r = 0; r < 32; r++) begin : g_reg
            if (r == 0 || r >= NUM_REGS) begin : g_zero
                assign cnt[r] = '0;
            end else begin : g_cnt
                regfile_scoreboard_cnt #(.CNT_W(CNT_W)) u_cnt (
                    .clk_i (clk_i),
                    .rst_i (rst_i),
                    .inc   (issue && sb.ID_reg_wr_en_i && (sb.ID_rd_i == 5'(r))),
                    .clr   (wb_hit && (sb.WB_rd_i == 5'(r))),
                    .flush (sb.flush_all_i),
                    .cnt   (cnt[r])
                );
            end
        end
    endgenerate

    // Total outstanding writes across all registers.
    always_comb begin
        sum = '0;
        for (int i = 1; i < 32; i++) sum = sum + 16'(cnt[i]);
    end

    assign sb.stall_o       = stall;
    assign sb.issue_o       = issue;
    assign sb.busy_o        = |cnt;
    assign sb.pending_cnt_o = (sum > 16'd63) ? 6'd63 : sum[5:0];

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles;

    // Stalled-cycle counter; survives flush, wraps naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            stall_cycles <= '0;
        else if (stall)
            stall_cycles <= stall_cycles + 32'd1;
    end

    assign sb.stall_cycles_o = stall_cycles;
`endif
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed scenarios followed by randomized traffic,
// checked each cycle against an array-of-counts reference model.
module tb_regfile_scoreboard;
    localparam int MAXC = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    regfile_scoreboard_if bus ();

    regfile_scoreboard #(.NUM_REGS(32), .CNT_W(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .sb    (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int pend[32];
    int unsigned stat = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) pend[i] = 0;
    endtask

    function automatic bit clr_hit(int r);
        return bus.WB_retire_i && bus.WB_reg_wr_en_i && r != 0 &&
               int'(bus.WB_rd_i) == r;
    endfunction

    function automatic bit haz(int rs, bit used);
        return used && rs != 0 && pend[rs] > 0 && !(pend[rs] == 1 && clr_hit(rs));
    endfunction

    function automatic int total();
        int s = 0;
        for (int i = 1; i < 32; i++) s += pend[i];
        return (s > 63) ? 63 : s;
    endfunction

    task automatic chk_status(string tag);
        chk({tag, "_busy"}, 32'(bus.busy_o), 32'(total() != 0));
        chk({tag, "_pend"}, 32'(bus.pending_cnt_o), 32'(total()));
`ifdef SCOREBOARD_STATS_EN
        chk({tag, "_stats"}, bus.stall_cycles_o, stat);
`endif
    endtask

    task automatic idle();
        bus.ID_valid_i = 0; bus.ID_rs1_i = 0; bus.ID_rs2_i = 0;
        bus.ID_rs1_used_i = 0; bus.ID_rs2_used_i = 0; bus.ID_rd_i = 0;
        bus.ID_reg_wr_en_i = 0; bus.EX_stall_i = 0; bus.WB_retire_i = 0;
        bus.WB_rd_i = 0; bus.WB_reg_wr_en_i = 0; bus.flush_all_i = 0;
    endtask

    task automatic set_id(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit we);
        bus.ID_valid_i = v; bus.ID_rs1_i = 5'(rs1); bus.ID_rs1_used_i = u1;
        bus.ID_rs2_i = 5'(rs2); bus.ID_rs2_used_i = u2;
        bus.ID_rd_i = 5'(rd); bus.ID_reg_wr_en_i = we;
    endtask

    task automatic set_wb(bit ret, int rd, bit we);
        bus.WB_retire_i = ret; bus.WB_rd_i = 5'(rd); bus.WB_reg_wr_en_i = we;
    endtask

    // One clock: check combinational outputs mid-cycle, then advance model.
    task automatic cycle(string tag);
        bit es, ei;
        int rd, inc_r, clr_r;
        @(negedge clk);
        rd = int'(bus.ID_rd_i);
        es = bus.ID_valid_i &&
             (haz(int'(bus.ID_rs1_i), bus.ID_rs1_used_i) ||
              haz(int'(bus.ID_rs2_i), bus.ID_rs2_used_i) ||
              (bus.ID_reg_wr_en_i && rd != 0 && pend[rd] == MAXC && !clr_hit(rd)));
        ei = bus.ID_valid_i && !es && !bus.EX_stall_i;
        chk({tag, "_stall"}, 32'(bus.stall_o), 32'(es));
        chk({tag, "_issue"}, 32'(bus.issue_o), 32'(ei));
        chk_status(tag);
        @(posedge clk);
        if (es) stat++;
        if (bus.flush_all_i) model_clear();
        else begin
            inc_r = (ei && bus.ID_reg_wr_en_i && rd != 0) ? rd : -1;
            clr_r = clr_hit(int'(bus.WB_rd_i)) ? int'(bus.WB_rd_i) : -1;
            if (inc_r != clr_r) begin
                if (inc_r > 0) pend[inc_r]++;
                if (clr_r > 0 && pend[clr_r] > 0) pend[clr_r]--;
            end
        end
        #1;
    endtask

    function automatic int rand_reg();
        return ($urandom % 4 == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 4));
    endfunction

    initial begin
        idle();
        model_clear();
        // Reset state
        #12;
        chk("rst_stall", 32'(bus.stall_o), 32'd0);
        chk("rst_issue", 32'(bus.issue_o), 32'd0);
        chk_status("rst");
        @(negedge clk); rst = 0;
        @(posedge clk); #1;

        // Load-use on x5
        set_id(1, 0, 0, 0, 0, 5, 1);            cycle("lu_issue");
        set_id(1, 5, 1, 0, 0, 0, 0);            cycle("lu_hold");
        chk("lu_cnt5", 32'(bus.pending_cnt_o), 32'd1);
        set_wb(1, 5, 1);                        cycle("lu_bypass");
        idle();                                 cycle("lu_after");
        chk("lu_clean", 32'(bus.pending_cnt_o), 32'd0);

        // x0 is never tracked
        set_id(1, 0, 0, 0, 0, 0, 1);            cycle("x0_issue");
        set_id(1, 0, 1, 0, 1, 0, 0);            cycle("x0_read");

        // Saturation on x7
        set_id(1, 0, 0, 0, 0, 7, 1);
        cycle("sat1"); cycle("sat2"); cycle("sat3");
        chk("sat_cnt", 32'(bus.pending_cnt_o), 32'd3);
        cycle("sat_full");
        set_wb(1, 7, 1);                        cycle("sat_swap");
        set_wb(0, 0, 0); set_id(0, 0, 0, 0, 0, 0, 0); cycle("sat_idle");
        chk("sat_still3", 32'(bus.pending_cnt_o), 32'd3);

        // Simultaneous inc/clr on x9 with cnt=2
        set_id(1, 0, 0, 0, 0, 9, 1);            cycle("ic_a"); cycle("ic_b");
        set_wb(1, 9, 1);                        cycle("ic_both");
        set_wb(0, 0, 0); set_id(1, 0, 0, 9, 1, 0, 0); cycle("ic_read");
        chk("ic_total", 32'(bus.pending_cnt_o), 32'd5);

        // Ten stalled cycles, then flush while still stalled
        set_id(1, 7, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle("st_loop");
        bus.flush_all_i = 1;                    cycle("flush");
        idle();                                 cycle("post_flush");
        chk("flush_busy", 32'(bus.busy_o), 32'd0);

        // Async reset mid-cycle with work pending
        set_id(1, 0, 0, 0, 0, 3, 1);            cycle("pre_rst_a");
        set_id(1, 3, 1, 0, 0, 4, 1);            cycle("pre_rst_b");
        idle();
        #1 rst = 1;
        model_clear(); stat = 0;
        #1;
        chk("mid_rst_stall", 32'(bus.stall_o), 32'd0);
        chk_status("mid_rst");
        @(negedge clk); #1 rst = 0;
        @(posedge clk); #1;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            set_id($urandom % 4 != 0, rand_reg(), $urandom % 2 == 0,
                   rand_reg(), $urandom % 2 == 0, rand_reg(), $urandom % 4 != 0);
            bus.EX_stall_i = ($urandom % 7 == 0);
            set_wb($urandom % 3 == 0, rand_reg(), $urandom % 8 != 0);
            bus.flush_all_i = ($urandom % 60 == 0);
            cycle("rnd");
        end
        idle(); cycle("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
